// File: rtl/c1541_track_ctrl_pkg.sv
// Shared types and helpers for the 1541 track-buffer scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package c1541_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    WR_REQ,
    WR_WAIT,
    RD_REQ,
    RD_WAIT
  } state_t;

  localparam int HT_MAX_C   = 83;
  localparam int HT_RESET_C = 34;

  // Direction of a stepper phase change: +1 one phase forward, -1 one phase
  // back, 0 for no change or an ambiguous half-turn jump.
  function automatic logic signed [1:0] step_dir(input logic [1:0] prev, input logic [1:0] cur);
    logic [1:0] diff;
    diff = cur - prev;
    case (diff)
      2'd1:    step_dir = 2'sd1;
      2'd3:    step_dir = -2'sd1;
      default: step_dir = 2'sd0;
    endcase
  endfunction

endpackage

// File: rtl/c1541_track_ctrl_stepper.sv
// Stepper phase decoder: saturating half-track position plus a change strobe.
// Latency: half_track and changed update one clk after a phase change.
// Backpressure: none; phases are sampled every clk, moves only while the motor runs.
module c1541_stepper
  import c1541_pkg::*;
#(
  parameter int HT_RESET = HT_RESET_C,
  parameter int HT_MAX   = HT_MAX_C
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] stp,
  input  logic       mtr,
  output logic [6:0] half_track,
  output logic       changed
);

  logic [1:0]        stp_prev;
  logic signed [1:0] dir;

  assign dir = step_dir(stp_prev, stp);

  // Track phase history every clk; move the head only with the motor on.
  always_ff @(posedge clk) begin
    if (reset) begin
      half_track <= 7'(HT_RESET);
      stp_prev   <= stp;
      changed    <= 1'b0;
    end else begin
      stp_prev <= stp;
      changed  <= 1'b0;
      if (mtr && dir == 2'sd1 && half_track != 7'(HT_MAX)) begin
        half_track <= half_track + 7'd1;
        changed    <= 1'b1;
      end else if (mtr && dir == -2'sd1 && half_track != 7'd0) begin
        half_track <= half_track - 7'd1;
        changed    <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/c1541_track_ctrl.sv
// Track-buffer scheduler: loads whole tracks from SD, writes dirty tracks back.
// Latency: SETTLE_CE ce ticks after the last head move, then one block per sd_ack handshake.
// Backpressure: one outstanding request, held until sd_ack is seen high.
module c1541_track_ctrl
  import c1541_pkg::*;
#(
  parameter int BLK_PER_TRK = 16,
  parameter int SETTLE_CE   = 2000,
  parameter int HT_RESET    = HT_RESET_C,
  parameter int HT_MAX      = HT_MAX_C
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           ce,
  input  logic [1:0]                     stp,
  input  logic                           mtr,
  input  logic                           img_mounted,
  input  logic                           img_size_nz,
  input  logic                           img_readonly,
  input  logic                           buf_wr,
  output logic [6:0]                     half_track,
  output logic [5:0]                     cur_track,
  output logic                           busy,
  output logic [31:0]                    sd_lba,
  output logic                           sd_rd,
  output logic                           sd_wr,
  input  logic                           sd_ack,
  output logic [$clog2(BLK_PER_TRK)-1:0] buf_blk
);

  localparam int BW = $clog2(BLK_PER_TRK);
  localparam int CW = $clog2(SETTLE_CE + 1);
  localparam logic [BW-1:0] BLK_LAST  = BW'(BLK_PER_TRK - 1);
  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CE);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [BW-1:0] blk;
  logic [BW-1:0] blk_nxt;
  logic [5:0]    ld_trk;
  logic [5:0]    tgt;
  logic          dirty;
  logic          need_load;
  logic          ack_prev;
  logic          mtr_prev;
  logic          ht_chg;
  logic          ack_rise;
  logic          ack_fall;
  logic          want_read;

  c1541_stepper #(
    .HT_RESET (HT_RESET),
    .HT_MAX   (HT_MAX)
  ) u_stepper (
    .clk        (clk),
    .reset      (reset),
    .stp        (stp),
    .mtr        (mtr),
    .half_track (half_track),
    .changed    (ht_chg)
  );

  // Block count is a power of two, so the LBA is a plain concatenation.
  function automatic logic [31:0] lba_of(input logic [5:0] trk, input logic [BW-1:0] b);
    return 32'({trk, b});
  endfunction

  assign tgt       = half_track[6:1];
  assign blk_nxt   = blk + 1'b1;
  assign ack_rise  = sd_ack && !ack_prev;
  assign ack_fall  = !sd_ack && ack_prev;
  assign want_read = (tgt != cur_track) || need_load;
  assign busy      = (state != IDLE) || need_load;
  assign buf_blk   = blk;

  // Transfer sequencer; img_mounted at the end overrides whatever the state did.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      blk       <= '0;
      ld_trk    <= '0;
      cur_track <= 6'(HT_RESET >> 1);
      dirty     <= 1'b0;
      need_load <= 1'b0;
      sd_rd     <= 1'b0;
      sd_wr     <= 1'b0;
      sd_lba    <= '0;
      ack_prev  <= 1'b0;
      mtr_prev  <= 1'b0;
    end else begin
      ack_prev <= sd_ack;
      mtr_prev <= mtr;
      case (state)
        IDLE: begin
          if (img_size_nz && (want_read || (mtr_prev && !mtr && dirty))) begin
            state <= SETTLE;
            cnt   <= SETTLE_LD;
          end
        end
        SETTLE: begin
          if (ht_chg) begin
            cnt <= SETTLE_LD;
          end else if (cnt == '0) begin
            blk <= '0;
            if (dirty && !img_readonly) begin
              state  <= WR_REQ;
              dirty  <= 1'b0;
              sd_wr  <= 1'b1;
              sd_lba <= lba_of(cur_track, '0);
            end else begin
              dirty <= 1'b0;
              if (want_read) begin
                state  <= RD_REQ;
                ld_trk <= tgt;
                sd_rd  <= 1'b1;
                sd_lba <= lba_of(tgt, '0);
              end else begin
                state <= IDLE;
              end
            end
          end else if (ce) begin
            cnt <= cnt - 1'b1;
          end
        end
        WR_REQ: begin
          if (ack_rise) begin
            sd_wr <= 1'b0;
            state <= WR_WAIT;
          end
        end
        WR_WAIT: begin
          if (ack_fall) begin
            if (blk == BLK_LAST) begin
              if (want_read) begin
                state  <= RD_REQ;
                blk    <= '0;
                ld_trk <= tgt;
                sd_rd  <= 1'b1;
                sd_lba <= lba_of(tgt, '0);
              end else begin
                state <= IDLE;
              end
            end else begin
              blk    <= blk_nxt;
              state  <= WR_REQ;
              sd_wr  <= 1'b1;
              sd_lba <= lba_of(cur_track, blk_nxt);
            end
          end
        end
        RD_REQ: begin
          if (ack_rise) begin
            sd_rd <= 1'b0;
            state <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (ack_fall) begin
            if (blk == BLK_LAST) begin
              cur_track <= ld_trk;
              need_load <= 1'b0;
              state     <= IDLE;
            end else begin
              blk    <= blk_nxt;
              state  <= RD_REQ;
              sd_rd  <= 1'b1;
              sd_lba <= lba_of(ld_trk, blk_nxt);
            end
          end
        end
        default: state <= IDLE;
      endcase

      // A drive write marks the buffer dirty, even against the save-entry clear;
      // data arriving from SD must not be mistaken for drive edits.
      if (buf_wr && (state == IDLE || state == SETTLE || state == WR_REQ || state == WR_WAIT)) begin
        dirty <= 1'b1;
      end

      // New image: discard buffer contents and abandon any transfer at once.
      if (img_mounted) begin
        need_load <= 1'b1;
        dirty     <= 1'b0;
        state     <= IDLE;
        sd_rd     <= 1'b0;
        sd_wr     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_c1541_track_ctrl.sv
// Scoreboard bench for c1541_track_ctrl: a track-level model predicts the SD
// request stream per stimulus phase; a host responder pops and compares.
module tb_c1541_track_ctrl;

  localparam int BPT    = 16;
  localparam int SETTLE = 24;
  localparam int QUIET  = 150;

  logic        clk, reset, ce, mtr, img_mounted, img_size_nz, img_readonly, buf_wr;
  logic [1:0]  stp;
  logic [6:0]  half_track;
  logic [5:0]  cur_track;
  logic        busy, sd_rd, sd_wr, sd_ack;
  logic [31:0] sd_lba;
  logic [3:0]  buf_blk;

  typedef struct {
    bit          wr;
    int unsigned lba;
  } req_t;

  req_t sb[$];
  int   n_cmp    = 0;
  int   n_bad    = 0;
  int   req_seen = 0;

  // Reference model state (track-level view of the drive).
  int m_ht, m_cur;
  bit m_dirty, m_need, m_ro, m_size;

  c1541_track_ctrl #(
    .BLK_PER_TRK (BPT),
    .SETTLE_CE   (SETTLE)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ce           (ce),
    .stp          (stp),
    .mtr          (mtr),
    .img_mounted  (img_mounted),
    .img_size_nz  (img_size_nz),
    .img_readonly (img_readonly),
    .buf_wr       (buf_wr),
    .half_track   (half_track),
    .cur_track    (cur_track),
    .busy         (busy),
    .sd_lba       (sd_lba),
    .sd_rd        (sd_rd),
    .sd_wr        (sd_wr),
    .sd_ack       (sd_ack),
    .buf_blk      (buf_blk)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    ce = 1'b0;
    forever begin
      @(negedge clk);
      ce = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  // Host side: service each request 4 clk later and check it against the scoreboard.
  initial begin : host
    req_t e;
    sd_ack = 1'b0;
    forever begin
      @(negedge clk);
      if ((sd_rd || sd_wr) && !sd_ack && !reset) begin
        req_seen++;
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL req: got rd=%0b wr=%0b lba=%0d, expected no request", sd_rd, sd_wr, sd_lba);
        end else begin
          e = sb.pop_front();
          if (sd_wr != e.wr || sd_rd != !e.wr || sd_lba != e.lba || 32'(buf_blk) != e.lba % BPT) begin
            n_bad++;
            $display("FAIL req: got rd=%0b wr=%0b lba=%0d blk=%0d, expected wr=%0b lba=%0d blk=%0d",
                     sd_rd, sd_wr, sd_lba, buf_blk, e.wr, e.lba, e.lba % BPT);
          end
        end
        repeat (4) @(negedge clk);
        sd_ack = 1'b1;
        repeat ($urandom_range(2, 4)) @(negedge clk);
        sd_ack = 1'b0;
      end
    end
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push_track(input bit wr, input int trk);
    for (int b = 0; b < BPT; b++) sb.push_back('{wr: wr, lba: trk * BPT + b});
  endtask

  // What one settle window should produce: save the old track, then load the new one.
  task automatic model_settle(input bit mtr_fell);
    if (!m_size) return;
    if (!((m_ht / 2 != m_cur) || m_need || (mtr_fell && m_dirty))) return;
    if (m_dirty && !m_ro) push_track(1'b1, m_cur);
    m_dirty = 1'b0;
    if ((m_ht / 2 != m_cur) || m_need) begin
      push_track(1'b0, m_ht / 2);
      m_cur  = m_ht / 2;
      m_need = 1'b0;
    end
  endtask

  task automatic wait_quiet(input string name);
    int quiet = 0;
    int t = 0;
    while (quiet < QUIET && t < 4000) begin
      @(negedge clk);
      t++;
      if (sd_rd && sd_wr) chk({name, "_overlap"}, 1, 0);
      if (sb.size() == 0 && !sd_rd && !sd_wr && !sd_ack) quiet++;
      else quiet = 0;
    end
    n_cmp++;
    if (quiet < QUIET) begin
      n_bad++;
      $display("FAIL %s_quiet: got %0d requests still pending, expected 0", name, sb.size());
    end
  endtask

  task automatic check_state(input string name);
    chk({name, "_ht"}, half_track, m_ht);
    chk({name, "_cur"}, cur_track, m_cur);
    chk({name, "_busy"}, busy, m_need);
  endtask

  // One stimulus phase, issued faster than the settle window so it collapses
  // into a single scheduling decision. Steps within a phase go one way only.
  task automatic run_phase(input string name, input bit do_wr, input bit do_mount, input bit mtr_on,
                           input int nsteps, input bit fwd, input bit jump, input bit mtr_off);
    bit mtr_now;
    bit fell;
    mtr_now = mtr || mtr_on;
    if (do_wr) m_dirty = 1'b1;
    if (do_mount) begin
      m_dirty = 1'b0;
      m_need  = 1'b1;
    end
    if (mtr_now) begin
      for (int i = 0; i < nsteps; i++) begin
        if (fwd) m_ht = (m_ht < 83) ? m_ht + 1 : 83;
        else     m_ht = (m_ht > 0) ? m_ht - 1 : 0;
      end
    end
    fell = mtr_off && mtr_now;
    model_settle(fell);

    if (mtr_on) begin
      mtr = 1'b1;
      clks(1);
    end
    if (do_wr) begin
      buf_wr = 1'b1;
      clks(1);
      buf_wr = 1'b0;
    end
    if (do_mount) begin
      img_mounted = 1'b1;
      clks(1);
      img_mounted = 1'b0;
    end
    for (int i = 0; i < nsteps; i++) begin
      stp = fwd ? stp + 2'd1 : stp - 2'd1;
      clks($urandom_range(1, 3));
    end
    if (jump) begin
      stp = stp + 2'd2;
      clks(2);
    end
    if (fell) begin
      mtr = 1'b0;
      clks(2);
    end
    wait_quiet(name);
    check_state(name);
  endtask

  initial begin : main
    int base;
    int t;
    reset = 1'b1; stp = 2'd0; mtr = 1'b0; img_mounted = 1'b0;
    img_size_nz = 1'b1; img_readonly = 1'b0; buf_wr = 1'b0;
    m_ht = 34; m_cur = 17; m_dirty = 0; m_need = 0; m_ro = 0; m_size = 1;
    clks(3);
    reset = 1'b0;
    clks(1);
    chk("rst_ht", half_track, 34);
    chk("rst_cur", cur_track, 17);
    chk("rst_busy", busy, 0);
    chk("rst_rd", sd_rd, 0);
    chk("rst_wr", sd_wr, 0);
    chk("rst_lba", sd_lba, 0);
    chk("rst_blk", buf_blk, 0);

    // Mount: full load of track 17.
    run_phase("mount", 0, 1, 0, 0, 1, 0, 0);
    // Three forward steps to half-track 37, then one back (same track).
    run_phase("step_fwd", 0, 0, 1, 3, 1, 0, 0);
    run_phase("step_back", 0, 0, 0, 1, 0, 0, 0);
    // Dirty buffer, move to track 19: save 18 then load 19.
    run_phase("dirty_move", 1, 0, 0, 2, 1, 0, 0);
    // Same with write protect: load only.
    img_readonly = 1'b1; m_ro = 1'b1;
    run_phase("ro_move", 1, 0, 0, 2, 1, 0, 0);
    img_readonly = 1'b0; m_ro = 1'b0;
    // Motor off with dirty buffer: write-back only.
    run_phase("mtr_off", 1, 0, 0, 0, 1, 0, 1);
    // Saturation at both ends.
    run_phase("sat_hi", 0, 0, 1, 52, 1, 0, 0);
    run_phase("sat_lo", 0, 0, 0, 90, 0, 0, 0);

    // Mount during a read: abandon it and reload the target track.
    m_ht = 4;
    model_settle(1'b0);
    base = req_seen;
    for (int i = 0; i < 4; i++) begin
      stp = stp + 2'd1;
      clks(2);
    end
    t = 0;
    while (!(req_seen == base + 6 && sd_ack && !sd_rd) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("abort_reach", t < 3000, 1);
    img_mounted = 1'b1;
    sb.delete();
    m_dirty = 1'b0; m_need = 1'b1; m_cur = 0;
    model_settle(1'b0);
    clks(1);
    img_mounted = 1'b0;
    chk("abort_busy", busy, 1);
    chk("abort_rd", sd_rd, 0);
    chk("abort_cur", cur_track, 0);
    wait_quiet("abort");
    check_state("abort");
    run_phase("abort_mtr_off", 0, 0, 0, 0, 1, 0, 1);

    // No image: nothing is fetched, busy follows need_load.
    img_size_nz = 1'b0; m_size = 1'b0;
    run_phase("nosize", 0, 1, 1, 2, 1, 0, 0);
    img_size_nz = 1'b1; m_size = 1'b1;
    run_phase("size_back", 0, 0, 0, 0, 1, 0, 0);

    for (int p = 0; p < 25; p++) begin
      m_ro = ($urandom_range(0, 3) == 0);
      img_readonly = m_ro;
      run_phase("rand", 1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0),
                ($urandom_range(0, 3) != 0), $urandom_range(0, 6), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
